// File: rtl/mutex_system_param.sv
// -----------------------------------------------------------------------------
// mutex_system_param
//
// Purpose:
//   Parametrised Murphi-style mutual-exclusion system. NODES nodes each hold a
//   2-bit protocol state (I/T/C/E) and share one semaphore bit x (1 = free).
//   Every cycle at most one guarded rule fires, selected by io_en_a. The rule
//   is applied on the rising edge that samples io_en_a, so its effect is
//   visible one cycle later. Optional round-robin fairness gates Crit entry.
//
// Ports:
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   io_en_a      : rule select; 0 = none, v>=1 -> node (v-1)/4, kind (v-1)%4,
//                  values above 4*NODES select nothing
//   io_n_state   : packed node states, node i at bits [2i+1:2i]
//   io_x         : semaphore, 1 = free
//   io_fired     : registered; 1 the cycle after a rule fired
//   io_grant_ptr : round-robin pointer (constant 0 when FAIR=0)
//   io_crit_cnt  : saturating count of Crit firings
//   io_violation : combinational mutual-exclusion invariant violation
// -----------------------------------------------------------------------------
module mutex_system_param #(
  parameter int NODES  = 3,
  parameter int RULE_W = $clog2(4*NODES+1),
  parameter int FAIR   = 0,
  parameter int CNT_W  = 8,
  localparam int PTR_W = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [RULE_W-1:0]    io_en_a,
  output logic [2*NODES-1:0]   io_n_state,
  output logic                 io_x,
  output logic                 io_fired,
  output logic [PTR_W-1:0]     io_grant_ptr,
  output logic [CNT_W-1:0]     io_crit_cnt,
  output logic                 io_violation
);

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_T = 2'd1,
    ST_C = 2'd2,
    ST_E = 2'd3
  } node_state_e;

  typedef enum logic [1:0] {
    K_TRY  = 2'd0,
    K_CRIT = 2'd1,
    K_EXIT = 2'd2,
    K_IDLE = 2'd3
  } rule_kind_e;

  localparam int NODE_SEL_W = RULE_W - 2;
  localparam logic [RULE_W:0] MAX_RULE = (RULE_W+1)'(4*NODES);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [2*NODES-1:0] state_q, state_d;
  logic               x_q, x_d;
  logic               fired_q, fired_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Rule decode
  // ---------------------------------------------------------------------------
  logic                  rule_valid;
  logic [RULE_W-1:0]     rule_m1;
  logic [NODE_SEL_W-1:0] rule_node;
  rule_kind_e            rule_kind;

  assign rule_valid = (io_en_a != '0) && ({1'b0, io_en_a} <= MAX_RULE);
  assign rule_m1    = io_en_a - RULE_W'(1);
  assign rule_node  = rule_m1[RULE_W-1:2];
  assign rule_kind  = rule_kind_e'(rule_m1[1:0]);

  // ---------------------------------------------------------------------------
  // Fairness: deadlock escape
  // If the node owning the grant is idle (I or E) while the semaphore is free,
  // it cannot use its turn, so any trying node may enter instead.
  // ---------------------------------------------------------------------------
  node_state_e ptr_st;
  logic        escape;

  always_comb begin
    ptr_st = ST_I;
    for (int i = 0; i < NODES; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        ptr_st = node_state_e'(state_q[2*i +: 2]);
      end
    end
  end

  assign escape = x_q && ((ptr_st == ST_I) || (ptr_st == ST_E));

  // ---------------------------------------------------------------------------
  // Per-node guards and next state
  // ---------------------------------------------------------------------------
  logic [NODES-1:0]   hit;
  logic [NODES-1:0]   fire_try;
  logic [NODES-1:0]   fire_crit;
  logic [NODES-1:0]   fire_exit;
  logic [NODES-1:0]   fire_idle;
  logic [NODES-1:0]   in_c;
  logic [2*NODES-1:0] node_next;
  logic [PTR_W-1:0]   next_ptr [NODES];

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    node_state_e st;
    logic        turn_ok;

    assign st = node_state_e'(state_q[2*gi +: 2]);

    // With fairness off the pointer plays no role in Crit entry.
    assign turn_ok = (FAIR == 0) || (ptr_q == PTR_W'(gi)) || escape;

    assign hit[gi]       = rule_valid && (rule_node == NODE_SEL_W'(gi));
    assign fire_try[gi]  = hit[gi] && (rule_kind == K_TRY)  && (st == ST_I);
    assign fire_crit[gi] = hit[gi] && (rule_kind == K_CRIT) && (st == ST_T)
                           && x_q && turn_ok;
    assign fire_exit[gi] = hit[gi] && (rule_kind == K_EXIT) && (st == ST_C);
    assign fire_idle[gi] = hit[gi] && (rule_kind == K_IDLE) && (st == ST_E);

    assign in_c[gi]     = (st == ST_C);
    assign next_ptr[gi] = PTR_W'((gi + 1) % NODES);

    assign node_next[2*gi +: 2] = fire_try[gi]  ? ST_T :
                                  fire_crit[gi] ? ST_C :
                                  fire_exit[gi] ? ST_E :
                                  fire_idle[gi] ? ST_I :
                                  st;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for shared state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = node_next;
    x_d     = x_q;
    fired_d = |(fire_try | fire_crit | fire_exit | fire_idle);
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (|fire_crit) begin
      x_d = 1'b0;
    end
    if (|fire_idle) begin
      x_d = 1'b1;
    end

    if ((|fire_crit) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (FAIR != 0) begin
      // At most one node fires, so at most one branch below is taken.
      // A Crit taken through the escape moves the turn past the entrant.
      for (int i = 0; i < NODES; i++) begin
        if (fire_idle[i] || (fire_crit[i] && escape)) begin
          ptr_d = next_ptr[i];
        end
      end
    end else begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      x_q     <= 1'b1;
      fired_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      fired_q <= fired_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariant: at most one node in C, and no node in C while x is free.
  // in_c & (in_c - 1) is non-zero exactly when two or more bits are set.
  // ---------------------------------------------------------------------------
  logic multi_c;
  assign multi_c      = (in_c & (in_c - NODES'(1))) != '0;
  assign io_violation = multi_c || ((|in_c) && x_q);

  assign io_n_state   = state_q;
  assign io_x         = x_q;
  assign io_fired     = fired_q;
  assign io_grant_ptr = ptr_q;
  assign io_crit_cnt  = cnt_q;

endmodule

// File: tb/tb_mutex_system_param.sv
// -----------------------------------------------------------------------------
// tb_mutex_system_param
//
// Purpose:
//   Self-checking bench for mutex_system_param. Three instances:
//     dut_a : NODES=3, FAIR=0, CNT_W=2 (basic protocol, blocking, saturation)
//     dut_b : NODES=3, FAIR=1, CNT_W=8 (round-robin gating and escape)
//     dut_c : NODES=1, FAIR=1          (single-node elaboration)
//   A table of {select, reset, rule, expected outputs} records drives the
//   instances; each record's expectation is queued when driven and popped
//   when the outputs are sampled. Hand-written sequences cover asynchronous
//   reset and a corrupted initial state.
// -----------------------------------------------------------------------------
module tb_mutex_system_param;

  typedef struct {
    int         sel;   // 0 = dut_a, 1 = dut_b, 2 = dut_c
    logic       rst;   // reset held through the sampling edge
    logic [7:0] en;
    logic [5:0] st;
    logic       x;
    logic       f;
    logic [1:0] ptr;
    logic [7:0] cnt;
  } vec_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic [3:0] en_a, en_b;
  logic [2:0] en_c;

  logic [5:0] st_a, st_b;
  logic [1:0] st_c;
  logic       x_a, x_b, x_c;
  logic       f_a, f_b, f_c;
  logic [1:0] ptr_a, ptr_b;
  logic [0:0] ptr_c;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b, cnt_c;
  logic       viol_a, viol_b, viol_c;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  mutex_system_param #(.NODES(3), .FAIR(0), .CNT_W(2)) dut_a (
    .clock(clk), .reset(rst_a), .io_en_a(en_a), .io_n_state(st_a),
    .io_x(x_a), .io_fired(f_a), .io_grant_ptr(ptr_a),
    .io_crit_cnt(cnt_a), .io_violation(viol_a)
  );

  mutex_system_param #(.NODES(3), .FAIR(1), .CNT_W(8)) dut_b (
    .clock(clk), .reset(rst_b), .io_en_a(en_b), .io_n_state(st_b),
    .io_x(x_b), .io_fired(f_b), .io_grant_ptr(ptr_b),
    .io_crit_cnt(cnt_b), .io_violation(viol_b)
  );

  mutex_system_param #(.NODES(1), .FAIR(1), .CNT_W(8)) dut_c (
    .clock(clk), .reset(rst_c), .io_en_a(en_c), .io_n_state(st_c),
    .io_x(x_c), .io_fired(f_c), .io_grant_ptr(ptr_c),
    .io_crit_cnt(cnt_c), .io_violation(viol_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic rst, input int en,
                              input int st, input logic x, input logic f,
                              input int ptr, input int cnt);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = 8'(en); v.st = 6'(st);
    v.x = x; v.f = f; v.ptr = 2'(ptr); v.cnt = 8'(cnt);
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic [31:0] a_st, a_x, a_f, a_ptr, a_cnt, a_viol;
    @(negedge clk);
    case (v.sel)
      0:       begin rst_a = v.rst; en_a = v.en[3:0]; end
      1:       begin rst_b = v.rst; en_b = v.en[3:0]; end
      default: begin rst_c = v.rst; en_c = v.en[2:0]; end
    endcase
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    case (v.sel)
      0: begin
        a_st = 32'(st_a); a_x = 32'(x_a); a_f = 32'(f_a);
        a_ptr = 32'(ptr_a); a_cnt = 32'(cnt_a); a_viol = 32'(viol_a);
      end
      1: begin
        a_st = 32'(st_b); a_x = 32'(x_b); a_f = 32'(f_b);
        a_ptr = 32'(ptr_b); a_cnt = 32'(cnt_b); a_viol = 32'(viol_b);
      end
      default: begin
        a_st = 32'(st_c); a_x = 32'(x_c); a_f = 32'(f_c);
        a_ptr = 32'(ptr_c); a_cnt = 32'(cnt_c); a_viol = 32'(viol_c);
      end
    endcase
    e = exp_q.pop_front();
    $display("step %0d dut=%0d rst=%0b en=%0d -> state=%0h x=%0h fired=%0h ptr=%0h cnt=%0h",
             idx, e.sel, e.rst, e.en, a_st, a_x, a_f, a_ptr, a_cnt);
    chk("n_state",   idx, a_st,   32'(e.st));
    chk("x",         idx, a_x,    32'(e.x));
    chk("fired",     idx, a_f,    32'(e.f));
    chk("grant_ptr", idx, a_ptr,  32'(e.ptr));
    chk("crit_cnt",  idx, a_cnt,  32'(e.cnt));
    chk("violation", idx, a_viol, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a = '0; en_b = '0; en_c = '0;
  endtask

  initial begin
    int c_now;

    // ---------------- dut_a: NODES=3, FAIR=0, CNT_W=2 ----------------
    // Basic Try/Crit/Exit/Idle on node 0
    vecs.push_back(mk(0, 0, 1, 'h01, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 2, 'h02, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 'h03, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4, 'h00, 1, 1, 0, 1));
    // Node 0 in C blocks node 1's Crit
    vecs.push_back(mk(0, 0, 1, 'h01, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 2, 'h02, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 5, 'h06, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 6, 'h06, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 3, 'h07, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 4, 'h04, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 6, 'h08, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 7, 'h0C, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 8, 'h00, 1, 1, 0, 3));
    // Out-of-range, zero and false-guard selects change nothing
    vecs.push_back(mk(0, 0, 13, 'h00, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0,  'h00, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 15, 'h00, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 4,  'h00, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 3,  'h00, 1, 0, 0, 3));
    // Reset in the same cycle as a Try: Try ignored, counter cleared
    vecs.push_back(mk(0, 1, 1, 'h00, 1, 0, 0, 0));
    // Five full cycles: counter goes 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      c_now = (k < 3) ? k : 3;
      vecs.push_back(mk(0, 0, 1, 'h01, 1, 1, 0, c_now));
      c_now = (k + 1 < 3) ? k + 1 : 3;
      vecs.push_back(mk(0, 0, 2, 'h02, 0, 1, 0, c_now));
      vecs.push_back(mk(0, 0, 3, 'h03, 0, 1, 0, c_now));
      vecs.push_back(mk(0, 0, 4, 'h00, 1, 1, 0, c_now));
    end

    // ---------------- dut_b: NODES=3, FAIR=1 ----------------
    vecs.push_back(mk(1, 0, 5,  'h04, 1, 1, 0, 0)); // n1 Try
    vecs.push_back(mk(1, 0, 6,  'h08, 0, 1, 2, 1)); // n1 Crit via escape, ptr->2
    vecs.push_back(mk(1, 0, 7,  'h0C, 0, 1, 2, 1));
    vecs.push_back(mk(1, 0, 8,  'h00, 1, 1, 2, 1)); // n1 Idle, ptr->2
    vecs.push_back(mk(1, 0, 9,  'h10, 1, 1, 2, 1)); // n2 Try
    vecs.push_back(mk(1, 0, 5,  'h14, 1, 1, 2, 1)); // n1 Try
    vecs.push_back(mk(1, 0, 6,  'h14, 1, 0, 2, 1)); // n1 Crit refused
    vecs.push_back(mk(1, 0, 10, 'h24, 0, 1, 2, 2)); // n2 Crit on its turn
    vecs.push_back(mk(1, 0, 11, 'h34, 0, 1, 2, 2));
    vecs.push_back(mk(1, 0, 12, 'h04, 1, 1, 0, 2)); // n2 Idle, ptr wraps
    vecs.push_back(mk(1, 0, 6,  'h08, 0, 1, 2, 3)); // escape again, ptr->2
    vecs.push_back(mk(1, 0, 2,  'h08, 0, 0, 2, 3)); // n0 Crit on I: no fire

    // ---------------- dut_c: NODES=1, FAIR=1 ----------------
    vecs.push_back(mk(2, 0, 1, 'h1, 1, 1, 0, 0));
    vecs.push_back(mk(2, 0, 2, 'h2, 0, 1, 0, 1));
    vecs.push_back(mk(2, 0, 3, 'h3, 0, 1, 0, 1));
    vecs.push_back(mk(2, 0, 4, 'h0, 1, 1, 0, 1));
    vecs.push_back(mk(2, 0, 5, 'h0, 1, 0, 0, 1));
    vecs.push_back(mk(2, 0, 7, 'h0, 1, 0, 0, 1));

    // ---------------- reset state ----------------
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = '0; en_b = '0; en_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_a", 0, 32'(st_a), 32'd0);
    chk("reset_x_a",     0, 32'(x_a),  32'd1);
    chk("reset_fired_a", 0, 32'(f_a),  32'd0);
    chk("reset_cnt_a",   0, 32'(cnt_a), 32'd0);
    chk("reset_state_b", 0, 32'(st_b), 32'd0);
    chk("reset_ptr_b",   0, 32'(ptr_b), 32'd0);
    chk("reset_x_c",     0, 32'(x_c),  32'd1);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) apply(vecs[i], i + 1);
    chk("scoreboard_empty", 0, 32'(exp_q.size()), 32'd0);

    // ---------------- corrupted initial state on dut_a ----------------
    @(negedge clk);
    force dut_a.state_q = 6'b001010; // n0=C, n1=C
    force dut_a.x_q     = 1'b1;
    #1;
    chk("violation_forced", 0, 32'(viol_a), 32'd1);
    release dut_a.state_q;
    release dut_a.x_q;
    #1;
    rst_a = 1'b1; // mid-cycle, no clock edge before the checks
    #1;
    chk("async_rst_viol_a",  0, 32'(viol_a), 32'd0);
    chk("async_rst_state_a", 0, 32'(st_a),   32'd0);
    chk("async_rst_x_a",     0, 32'(x_a),    32'd1);
    @(negedge clk);
    rst_a = 1'b0;

    // ---------------- async reset mid-operation on dut_b (n1 in C) ----------------
    @(negedge clk);
    chk("pre_rst_state_b", 0, 32'(st_b), 32'h08);
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_rst_state_b", 0, 32'(st_b),   32'd0);
    chk("async_rst_x_b",     0, 32'(x_b),    32'd1);
    chk("async_rst_ptr_b",   0, 32'(ptr_b),  32'd0);
    chk("async_rst_cnt_b",   0, 32'(cnt_b),  32'd0);
    chk("async_rst_viol_b",  0, 32'(viol_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
